// File: rtl/display_bcd_converter_if.sv
// -----------------------------------------------------------------------------
// display_bcd_converter_if
//
// Bundles the request handshake and the result bus of display_bcd_converter.
//
// Handshake (valid/ready): a value on i_data is transferred on the rising
// i_clk edge where i_valid and o_ready are both high. The source may change
// i_data or drop i_valid freely at any time. The converter samples i_data
// only on that transfer edge. The source never has to wait for o_ready before
// it raises i_valid.
//
// Signals:
//   i_data     [7:0]  binary value to convert            (master -> slave)
//   i_valid           i_data valid                       (master -> slave)
//   o_ready           converter idle, can accept         (slave -> master)
//   o_bcd      [11:0] {hundreds, tens, ones} BCD         (slave -> master)
//   o_display  [7:0]  {tens, ones} or overflow word      (slave -> master)
//   o_overflow        last result > 99                   (slave -> master)
//   o_negative        sign of last input (signed build)  (slave -> master)
//   o_done            one-cycle pulse on result update   (slave -> master)
//   o_busy            conversion in progress             (slave -> master)
//   dbg_state  [1:0]  FSM state, for observation only    (slave -> master)
// -----------------------------------------------------------------------------
interface display_bcd_converter_if;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_bcd;
  logic [7:0]  o_display;
  logic        o_overflow;
  logic        o_negative;
  logic        o_done;
  logic        o_busy;
  logic [1:0]  dbg_state;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_bcd,
    input  o_display,
    input  o_overflow,
    input  o_negative,
    input  o_done,
    input  o_busy,
    input  dbg_state
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_bcd,
    output o_display,
    output o_overflow,
    output o_negative,
    output o_done,
    output o_busy,
    output dbg_state
  );
endinterface

// File: rtl/display_bcd_converter.sv
// -----------------------------------------------------------------------------
// display_bcd_converter
//
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble) that feeds
// the two-digit seven-segment display driver, so values are shown in decimal.
//
// Ports:
//   i_clk     system clock (same domain as the display driver)
//   i_resetn  synchronous, active-low reset
//   bus       display_bcd_converter_if.slave: valid/ready request plus the
//             registered result (o_bcd, o_display, o_overflow, o_negative),
//             the o_done pulse, o_ready/o_busy and the FSM state (dbg_state)
//
// Parameters:
//   OVF_SATURATE  1: on a result > 99 o_display shows OVF_VALUE
//                 0: on a result > 99 o_display shows the low two digits
//   OVF_VALUE     display word used on overflow when OVF_SATURATE = 1
//
// Build option:
//   DISPLAY_SIGNED_EN  when defined, i_data is two's complement; the
//                      magnitude is converted and the sign is reported on
//                      o_negative. When undefined, i_data is unsigned and
//                      o_negative is tied low. Timing is the same either way.
//
// Timing: accept edge = edge 0, eight shift edges (1..8), results and o_done
// update at edge 9. The FSM is back in IDLE while o_done is high, so the next
// value can be accepted on the edge that follows the result edge.
// -----------------------------------------------------------------------------
module display_bcd_converter #(
  parameter bit         OVF_SATURATE = 1'b1,
  parameter logic [7:0] OVF_VALUE    = 8'h99
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  display_bcd_converter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [19:0] sr;         // {hundreds, tens, ones, binary operand}
  logic [2:0]  step_cnt;
  logic [19:0] sr_adj;     // sr after the add-3 correction
  logic [19:0] sr_shift;   // corrected value shifted left by one
  logic [7:0]  operand;
  logic        accept;
  logic        res_ovf;

  logic [11:0] bcd_q;
  logic [7:0]  display_q;
  logic        overflow_q;
  logic        done_q;

  assign accept = bus.i_valid && (state == ST_IDLE);

  // Operand selection: magnitude in the signed build, raw value otherwise.
  // In the signed build 8'h80 negates to itself, which read unsigned is 128.
`ifdef DISPLAY_SIGNED_EN
  logic sign_q;
  logic negative_q;

  assign operand = bus.i_data[7] ? (8'd0 - bus.i_data) : bus.i_data;
`else
  assign operand = bus.i_data;
`endif

  // Add 3 to every BCD nibble that is 5 or more, then shift. A nibble is at
  // most 9 before correction, so the sum never exceeds 12 and never wraps.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[8 + 4*i +: 4] >= 4'd5) begin
        sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = sr_adj << 1;
  end

  // Result > 99 exactly when the hundreds digit is non-zero.
  assign res_ovf = (sr[19:16] != 4'd0);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state      <= ST_IDLE;
      sr         <= '0;
      step_cnt   <= '0;
      bcd_q      <= '0;
      display_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr       <= {12'd0, operand};
            step_cnt <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr       <= sr_shift;
          step_cnt <= step_cnt + 3'd1;
          if (step_cnt == 3'd7) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_q      <= sr[19:8];
          overflow_q <= res_ovf;
          display_q  <= (res_ovf && OVF_SATURATE) ? OVF_VALUE : sr[15:8];
          done_q     <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DISPLAY_SIGNED_EN
  // Sign is captured with the operand and published with the result.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      sign_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      if (accept) begin
        sign_q <= bus.i_data[7];
      end
      if (state == ST_DONE) begin
        negative_q <= sign_q;
      end
    end
  end

  assign bus.o_negative = negative_q;
`else
  assign bus.o_negative = 1'b0;
`endif

  assign bus.o_ready    = (state == ST_IDLE);
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_bcd      = bcd_q;
  assign bus.o_display  = display_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_done     = done_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_display_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_display_bcd_converter
//
// Self-checking bench for display_bcd_converter. Expected results are computed
// with divide/modulo arithmetic and queued when a value is driven; they are
// popped and compared whenever the converter pulses o_done.
// -----------------------------------------------------------------------------
module tb_display_bcd_converter;

  localparam bit         OVF_SAT = 1'b1;
  localparam logic [7:0] OVF_VAL = 8'h99;
`ifdef DISPLAY_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  display_bcd_converter_if bus ();

  display_bcd_converter #(
    .OVF_SATURATE (OVF_SAT),
    .OVF_VALUE    (OVF_VAL)
  ) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  // ---------------- scoreboard ----------------
  // Packed as {bcd[11:0], display[7:0], overflow, negative}
  logic [21:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  logic        got_done;
  logic [21:0] prev_exp;

  function automatic logic [21:0] exp_of(input logic [7:0] d);
    logic [7:0]  mag;
    logic        neg;
    int          h, t, o;
    logic [11:0] bcd;
    logic        ovf;
    logic [7:0]  disp;
    if (SIGNED_BUILD && d[7]) begin
      neg = 1'b1;
      mag = 8'd0 - d;
    end else begin
      neg = 1'b0;
      mag = d;
    end
    h    = int'(mag) / 100;
    t    = (int'(mag) / 10) % 10;
    o    = int'(mag) % 10;
    bcd  = {h[3:0], t[3:0], o[3:0]};
    ovf  = (h != 0);
    disp = (ovf && OVF_SAT) ? OVF_VAL : {t[3:0], o[3:0]};
    return {bcd, disp, ovf, neg};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: advance past the edge, sample, and service the scoreboard.
  task automatic step();
    logic [21:0] e;
    logic [21:0] act;
    @(posedge clk);
    #1;
    got_done = 1'b0;
    if (bus.o_done === 1'b1) begin
      got_done = 1'b1;
      act = {bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got bcd=%h disp=%h ovf=%b neg=%b, required no o_done",
                 bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative);
      end else begin
        e = exp_q.pop_front();
        prev_exp = e;
        if (act !== e) begin
          n_fail++;
          $display("FAIL result: got bcd=%h disp=%h ovf=%b neg=%b, required bcd=%h disp=%h ovf=%b neg=%b",
                   act[21:10], act[9:2], act[1], act[0], e[21:10], e[9:2], e[1], e[0]);
        end
      end
    end
  endtask

  // Drive one value for one edge; the DUT must be idle when this is called.
  task automatic send(input logic [7:0] v);
    bus.i_data  = v;
    bus.i_valid = 1'b1;
    exp_q.push_back(exp_of(v));
    step();
    bus.i_valid = 1'b0;
    bus.i_data  = 8'($urandom_range(0, 255));
  endtask

  // Step until o_done (bounded); lat is the edge count after the accept edge.
  task automatic wait_result(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (got_done) begin
        lat = i + 1;
        break;
      end
    end
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL timeout: got no o_done within %0d cycles, required o_done", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn      = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'd0;
    repeat (3) step();
    n_checks++;
    if ({bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative, bus.o_done} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bcd=%h disp=%h ovf=%b neg=%b done=%b, required all 0",
               bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative, bus.o_done);
    end
    n_checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b busy=%b state=%0d, required ready=1 busy=0 state=0",
               bus.o_ready, bus.o_busy, bus.dbg_state);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int bad_busy;
    send(8'd42);
    bad_busy = 0;
    // Edges 0..8: converter must report busy and give no result.
    if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) bad_busy++;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1 || got_done) bad_busy++;
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL busy_window: got %0d cycles not busy in 1..9, required 0", bad_busy);
    end
    step();
    n_checks++;
    if (!got_done || bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_42: got done=%b ready=%b at edge 9, required done=1 ready=1",
               got_done, bus.o_ready);
    end
    n_checks++;
    if (bus.o_bcd !== 12'h042 || bus.o_display !== 8'h42 || bus.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL value_42: got bcd=%h disp=%h ovf=%b, required 042/42/0",
               bus.o_bcd, bus.o_display, bus.o_overflow);
    end
    step();
    n_checks++;
    if (bus.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got o_done=%b one cycle later, required 0", bus.o_done);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] vals[4];
    int lat;
    vals = '{8'd0, 8'd99, 8'd100, 8'd255};
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      wait_result(20, lat);
      n_checks++;
      if (lat != 9) begin
        n_fail++;
        $display("FAIL latency_bound: got %0d cycles for %0d, required 9", lat, vals[i]);
      end
    end
    // Explicit check of the saturated display word after 255.
    n_checks++;
    if (bus.o_display !== (SIGNED_BUILD ? 8'h01 : 8'h99) ||
        bus.o_overflow !== (SIGNED_BUILD ? 1'b0 : 1'b1)) begin
      n_fail++;
      $display("FAIL ovf_255: got disp=%h ovf=%b, required disp=%h ovf=%b",
               bus.o_display, bus.o_overflow, SIGNED_BUILD ? 8'h01 : 8'h99, !SIGNED_BUILD);
    end
  endtask

  task automatic test_hold();
    logic [21:0] held;
    int lat;
    held = prev_exp;
    send(8'd37);
    repeat (5) step();
    n_checks++;
    if ({bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative} !== held) begin
      n_fail++;
      $display("FAIL hold_busy: got bcd=%h disp=%h, required previous bcd=%h disp=%h",
               bus.o_bcd, bus.o_display, held[21:10], held[9:2]);
    end
    wait_result(20, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.i_data  = 8'd7;
    bus.i_valid = 1'b1;
    exp_q.push_back(exp_of(8'd7));
    step();
    // Keep valid high with new data while busy: must be ignored until idle.
    bus.i_data = 8'd13;
    wait_result(20, lat);
    n_checks++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL latency_7: got %0d cycles, required 9", lat);
    end
    // Ready is high during the o_done cycle, so 13 is taken on the next edge.
    exp_q.push_back(exp_of(8'd13));
    step();
    bus.i_valid = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_on_done: got busy=%b, required 1", bus.o_busy);
    end
    wait_result(20, lat);
    n_checks++;
    if (lat != 9 || bus.o_bcd !== 12'h013) begin
      n_fail++;
      $display("FAIL result_13: got lat=%0d bcd=%h, required lat=9 bcd=013", lat, bus.o_bcd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    send(8'd200);
    repeat (3) step();           // edges 1..3: three shifts done
    void'(exp_q.pop_back());     // in-flight value is discarded by reset
    resetn = 1'b0;
    step();                      // reset during the 4th shift
    resetn = 1'b1;
    n_checks++;
    if ({bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_negative, bus.o_done} !== 23'd0 ||
        bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got bcd=%h disp=%h ovf=%b done=%b ready=%b, required 0/0/0/0/1",
               bus.o_bcd, bus.o_display, bus.o_overflow, bus.o_done, bus.o_ready);
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (got_done) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d o_done pulses, required 0", stray);
    end
    send(8'd58);
    wait_result(20, lat);
    n_checks++;
    if (lat != 9 || bus.o_bcd !== 12'h058) begin
      n_fail++;
      $display("FAIL after_reset_58: got lat=%0d bcd=%h, required lat=9 bcd=058", lat, bus.o_bcd);
    end
  endtask

  task automatic test_signed();
    int lat;
    send(8'hFF);
    wait_result(20, lat);
    n_checks++;
    if (bus.o_bcd !== (SIGNED_BUILD ? 12'h001 : 12'h255) || bus.o_negative !== SIGNED_BUILD) begin
      n_fail++;
      $display("FAIL signed_ff: got bcd=%h neg=%b, required bcd=%h neg=%b",
               bus.o_bcd, bus.o_negative, SIGNED_BUILD ? 12'h001 : 12'h255, SIGNED_BUILD);
    end
    send(8'h80);
    wait_result(20, lat);
    n_checks++;
    if (bus.o_bcd !== 12'h128 || bus.o_overflow !== 1'b1 || bus.o_negative !== SIGNED_BUILD) begin
      n_fail++;
      $display("FAIL signed_80: got bcd=%h ovf=%b neg=%b, required bcd=128 ovf=1 neg=%b",
               bus.o_bcd, bus.o_overflow, bus.o_negative, SIGNED_BUILD);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom_range(0, 255)));
      wait_result(20, lat);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    got_done = 1'b0;
    prev_exp = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    test_random();
    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d expected results never produced, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
